// File: rtl/index_test_pkg.sv
// rtl/index_test_pkg.sv - shared constants for the index loader and its downstream index model
package index_test_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } ld_state_t;

  localparam int MEM_LO  = 2;
  localparam int MEM_HI  = 5;
  localparam int BYTE_HI = 15;
  localparam int BYTE_LO = 8;

  // Downstream index model: out_mem_8bit[OUT_LO..OUT_HI] mirrors in_mem_8bit[MEM_HI..MEM_LO].
  localparam int OUT_LO  = 4;
  localparam int OUT_HI  = 7;

  function automatic logic [2:0] slot_idx(input int slot);
    return 3'(slot);
  endfunction

endpackage

// File: rtl/index_test.sv
// rtl/index_test.sv - combinational downstream index model fed by the loader frame array
module index_test
  import index_test_pkg::*;
(
  input  logic [BYTE_HI:BYTE_LO] in_mem_8bit  [MEM_LO:MEM_HI],
  output logic [7:0]             out_mem_8bit [OUT_LO:OUT_HI]
);

  always_comb begin
    for (int k = 0; k <= OUT_HI - OUT_LO; k++) begin
      out_mem_8bit[OUT_LO + k] = in_mem_8bit[MEM_HI - k];
    end
  end

endmodule

// File: rtl/index_mem_loader.sv
// rtl/index_mem_loader.sv - packs a byte stream into a 4-slot frame array with pad, overrun and hold/ack
module index_mem_loader
  import index_test_pkg::*;
#(
  parameter int         FRAME_LEN = 4,
  parameter logic [7:0] PAD_BYTE  = 8'd0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [BYTE_HI:BYTE_LO] in_data,
  input  logic                   in_valid,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic [BYTE_HI:BYTE_LO] mem_out [MEM_LO:MEM_HI],
  output logic                   frame_valid,
  input  logic                   frame_ack,
  output logic                   short_frame,
  output logic [7:0]             overrun_cnt
);

  localparam logic [2:0] FIRST_IDX = slot_idx(MEM_LO);
  localparam logic [2:0] LAST_IDX  = slot_idx(MEM_LO + FRAME_LEN - 1);

  ld_state_t state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic accept, commit, drop;

  // Bytes of the frame in progress; mem_out only changes when a frame completes.
  logic [BYTE_HI:BYTE_LO] fill_q [MEM_LO:MEM_HI];

  assign in_ready    = (state_q != HOLD);
  assign frame_valid = (state_q == HOLD);
  assign accept      = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= FIRST_IDX;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    commit  = 1'b0;
    drop    = 1'b0;
    case (state_q)
      IDLE, FILL: begin
        if (accept) begin
          if (in_last) begin
            state_d = HOLD;
            idx_d   = FIRST_IDX;
            commit  = 1'b1;
          end else if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            idx_d   = FIRST_IDX;
            drop    = 1'b1;
          end else begin
            state_d = FILL;
            idx_d   = idx_q + 3'd1;
          end
        end
      end
      HOLD: begin
        if (frame_ack) begin
          state_d = IDLE;
          idx_d   = FIRST_IDX;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = FIRST_IDX;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = MEM_LO; i <= MEM_HI; i++) begin
        mem_out[i] <= '0;
        fill_q[i]  <= '0;
      end
      short_frame <= 1'b0;
      overrun_cnt <= 8'd0;
    end else begin
      if (accept && !in_last) begin
        fill_q[idx_q] <= in_data;
      end
      // Earlier slots come from the fill buffer, the current byte lands at idx_q, the rest is padded.
      if (commit) begin
        for (int i = MEM_LO; i <= MEM_HI; i++) begin
          if (slot_idx(i) < idx_q) begin
            mem_out[i] <= fill_q[i];
          end else if (slot_idx(i) == idx_q) begin
            mem_out[i] <= in_data;
          end else begin
            mem_out[i] <= PAD_BYTE;
          end
        end
        short_frame <= (idx_q != LAST_IDX);
      end else if (state_q == HOLD && frame_ack) begin
        short_frame <= 1'b0;
      end
      if (drop && overrun_cnt != 8'hFF) begin
        overrun_cnt <= overrun_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_index_mem_loader.sv
// tb/tb_index_mem_loader.sv - scoreboard bench for index_mem_loader chained with the index_test model
module tb_index_mem_loader;

  typedef struct {
    logic [3:0][7:0] b;
    logic            sh;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'd0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic [15:8] mem_out [2:5];
  logic       frame_valid;
  logic       frame_ack = 1'b0;
  logic       short_frame;
  logic [7:0] overrun_cnt;
  logic [7:0] out_mem [4:7];

  int n_cmp = 0;
  int n_bad = 0;
  frame_t sb_q[$];
  frame_t last_exp;

  always #5 clk = ~clk;

  index_mem_loader #(.FRAME_LEN(4), .PAD_BYTE(8'd0)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .mem_out(mem_out), .frame_valid(frame_valid), .frame_ack(frame_ack),
    .short_frame(short_frame), .overrun_cnt(overrun_cnt)
  );

  index_test u_ds (.in_mem_8bit(mem_out), .out_mem_8bit(out_mem));

  task automatic send_frame(input logic [3:0][7:0] b, input int n, input logic with_last);
    frame_t e;
    for (int i = 0; i < 4; i++) e.b[i] = (i < n) ? b[i] : 8'd0;
    e.sh = (n < 4);
    if (with_last) sb_q.push_back(e);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = b[i];
      in_last  = with_last && (i == n - 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic check_frame(input string tag, input logic do_ack);
    frame_t e;
    int cyc = 0;
    while (!frame_valid && cyc < 4) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_cmp++;
    if (cyc !== 0) begin
      n_bad++;
      $display("FAIL %s latency: frame_valid after %0d extra cycles, required 0", tag, cyc);
    end
    if (sb_q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s scoreboard empty: got 0 entries, required 1", tag);
      return;
    end
    e = sb_q.pop_front();
    last_exp = e;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (mem_out[2+i] !== e.b[i]) begin
        n_bad++;
        $display("FAIL %s mem_out[%0d]: got %h, required %h", tag, 2+i, mem_out[2+i], e.b[i]);
      end
      n_cmp++;
      if (out_mem[4+i] !== e.b[3-i]) begin
        n_bad++;
        $display("FAIL %s out_mem_8bit[%0d]: got %h, required %h", tag, 4+i, out_mem[4+i], e.b[3-i]);
      end
    end
    n_cmp++;
    if (short_frame !== e.sh) begin
      n_bad++;
      $display("FAIL %s short_frame: got %b, required %b", tag, short_frame, e.sh);
    end
    if (do_ack) begin
      frame_ack = 1'b1;
      @(posedge clk); #1;
      frame_ack = 1'b0;
      n_cmp++;
      if (frame_valid !== 1'b0 || short_frame !== 1'b0 || in_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL %s release: got fv=%b sh=%b rdy=%b, required 0 0 1", tag, frame_valid, short_frame, in_ready);
      end
    end
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if (frame_valid !== 1'b0 || short_frame !== 1'b0 || overrun_cnt !== 8'd0 ||
        mem_out[2] !== 8'd0 || mem_out[5] !== 8'd0) begin
      n_bad++;
      $display("FAIL reset outputs: got fv=%b sh=%b ovr=%h m2=%h m5=%h, required all 0",
               frame_valid, short_frame, overrun_cnt, mem_out[2], mem_out[5]);
    end
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset in_ready: got %b, required 1", in_ready);
    end
  endtask

  task automatic test_full_frame();
    send_frame({8'h44, 8'h33, 8'h22, 8'h11}, 4, 1'b1);
    check_frame("full", 1'b1);
  endtask

  task automatic test_short_frame();
    send_frame({8'h00, 8'h00, 8'hB2, 8'hA1}, 2, 1'b1);
    check_frame("short2", 1'b1);
    send_frame({8'h00, 8'h00, 8'h00, 8'hC3}, 1, 1'b1);
    check_frame("short1", 1'b1);
    send_frame({8'h00, 8'h5C, 8'h5B, 8'h5A}, 3, 1'b1);
    check_frame("short3", 1'b1);
  endtask

  task automatic test_overrun();
    send_frame({8'hD4, 8'hD3, 8'hD2, 8'hD1}, 4, 1'b0);
    n_cmp++;
    if (overrun_cnt !== 8'd1 || frame_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL overrun first: got ovr=%h fv=%b, required 01 0", overrun_cnt, frame_valid);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (mem_out[2+i] !== last_exp.b[i]) begin
        n_bad++;
        $display("FAIL overrun keep mem_out[%0d]: got %h, required %h", 2+i, mem_out[2+i], last_exp.b[i]);
      end
    end
    for (int r = 1; r < 255; r++) send_frame({8'($urandom), 8'h02, 8'h03, 8'h04}, 4, 1'b0);
    n_cmp++;
    if (overrun_cnt !== 8'hFF) begin
      n_bad++;
      $display("FAIL overrun at 255: got %h, required ff", overrun_cnt);
    end
    for (int r = 255; r < 300; r++) send_frame({8'h09, 8'h08, 8'h07, 8'h06}, 4, 1'b0);
    n_cmp++;
    if (overrun_cnt !== 8'hFF) begin
      n_bad++;
      $display("FAIL overrun saturate: got %h, required ff", overrun_cnt);
    end
    send_frame({8'h78, 8'h56, 8'h34, 8'h12}, 4, 1'b1);
    check_frame("after_overrun", 1'b1);
  endtask

  task automatic test_hold_stall();
    send_frame({8'hEE, 8'hDD, 8'hCC, 8'hBB}, 4, 1'b1);
    check_frame("hold", 1'b0);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_last  = c[0];
      in_data  = 8'h90 + 8'(c);
      @(posedge clk); #1;
      n_cmp++;
      if (in_ready !== 1'b0 || frame_valid !== 1'b1 || mem_out[2] !== 8'hBB || mem_out[5] !== 8'hEE) begin
        n_bad++;
        $display("FAIL hold cycle %0d: got rdy=%b fv=%b m2=%h m5=%h, required 0 1 bb ee",
                 c, in_ready, frame_valid, mem_out[2], mem_out[5]);
      end
    end
    frame_ack = 1'b1;
    in_last   = 1'b1;
    @(posedge clk); #1;
    frame_ack = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1 || frame_valid !== 1'b0 || mem_out[2] !== 8'hBB) begin
      n_bad++;
      $display("FAIL hold release: got rdy=%b fv=%b m2=%h, required 1 0 bb", in_ready, frame_valid, mem_out[2]);
    end
    frame_ack = 1'b1;
    @(posedge clk); #1;
    frame_ack = 1'b0;
    send_frame({8'h04, 8'h03, 8'h02, 8'h01}, 4, 1'b1);
    check_frame("ack_ignored_idle", 1'b1);
  endtask

  task automatic test_async_reset();
    send_frame({8'h00, 8'h00, 8'h62, 8'h61}, 2, 1'b0);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (frame_valid !== 1'b0 || short_frame !== 1'b0 || overrun_cnt !== 8'd0 || in_ready !== 1'b1 ||
        mem_out[2] !== 8'd0 || mem_out[3] !== 8'd0 || mem_out[4] !== 8'd0 || mem_out[5] !== 8'd0) begin
      n_bad++;
      $display("FAIL async reset: got fv=%b sh=%b ovr=%h rdy=%b m2=%h m5=%h, required 0 0 00 1 00 00",
               frame_valid, short_frame, overrun_cnt, in_ready, mem_out[2], mem_out[5]);
    end
    @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;
    send_frame({8'h74, 8'h73, 8'h72, 8'h71}, 4, 1'b1);
    check_frame("post_reset", 1'b0);
    rst = 1'b1;
    #1;
    n_cmp++;
    if (frame_valid !== 1'b0 || mem_out[5] !== 8'd0) begin
      n_bad++;
      $display("FAIL reset in hold: got fv=%b m5=%h, required 0 00", frame_valid, mem_out[5]);
    end
    @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 6; f++) begin
      logic [3:0][7:0] b;
      int n;
      n = $urandom_range(1, 4);
      for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
      send_frame(b, n, 1'b1);
      check_frame("b2b", 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_short_frame();
    test_overrun();
    test_hold_stall();
    test_async_reset();
    test_back_to_back();
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard drain: got %0d left, required 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/index_mem_loader.md
INDEX_MEM_LOADER -- requirements
Module: index_mem_loader

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 4, number of bytes per frame; fixed at 4 for this release.
REQ-002 SHALL have parameter PAD_BYTE, default 8'd0, fill value for unwritten slots of a short frame.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port in_data, input, [15:8], the byte being offered.
REQ-006 SHALL have port in_valid, input, 1, in_data is valid this cycle.
REQ-007 SHALL have port in_last, input, 1, qualified by in_valid; marks the final byte of a frame.
REQ-008 SHALL have port in_ready, output, 1, the loader accepts in_data this cycle.
REQ-009 SHALL have port mem_out, output reg, [15:8] x [2:5], the frame array feeding the downstream in_mem_8bit port.
REQ-010 SHALL have port frame_valid, output, 1, mem_out holds a complete frame.
REQ-011 SHALL have port frame_ack, input, 1, the downstream stage has consumed the frame.
REQ-012 SHALL have port short_frame, output, 1, the held frame ended via in_last before slot 5.
REQ-013 SHALL have port overrun_cnt, output, [7:0], count of frames dropped because in_last was absent at slot 5.

Function
REQ-014 SHALL implement states IDLE, FILL and HOLD.
REQ-015 A byte SHALL be accepted only when in_valid and in_ready are both 1; in_ready SHALL be 1 in IDLE and FILL and 0 in HOLD.
REQ-016 Write index SHALL start at 2; the Nth accepted byte (N=0..3) SHALL be written to mem_out[2+N].
REQ-017 IDLE->FILL SHALL occur on the first accepted byte without in_last.
REQ-018 Any state accepting a byte with in_last SHALL go to HOLD on the next edge, with frame_valid=1 in that same cycle.
REQ-019 For in_last accepted at index k<5, slots k+1..5 SHALL be written with PAD_BYTE on the same edge, and short_frame SHALL be set to 1.
REQ-020 For a byte accepted at index 5 without in_last, the frame SHALL be discarded, overrun_cnt SHALL be incremented, the state SHALL return to IDLE with index 2, and mem_out SHALL keep its previous contents.
REQ-021 overrun_cnt SHALL saturate at 8'hFF and never wrap.
REQ-022 In HOLD, mem_out SHALL remain stable until frame_ack=1.
REQ-023 frame_ack=1 in HOLD SHALL cause HOLD->IDLE on that edge, clearing frame_valid and short_frame and resetting the index to 2; in_ready SHALL be 1 in the following cycle.
REQ-024 frame_ack in IDLE or FILL SHALL be ignored.
REQ-025 Latency SHALL be 1 cycle from the edge accepting the in_last byte to frame_valid=1.
REQ-026 No byte SHALL be accepted in the frame_ack cycle, so there is no same-cycle accept-and-release.
REQ-027 Index arithmetic SHALL use a 3-bit counter over 2..5, and the value 6 SHALL never be reached.

Reset
REQ-028 On rst=1, without waiting for clk, the block SHALL enter IDLE with index 2, mem_out[2..5]=0, frame_valid=0, short_frame=0, overrun_cnt=0.
REQ-029 Reset asserted mid-FILL or mid-HOLD SHALL discard the partial or held frame with no overrun count.
REQ-030 in_ready SHALL be 1 on the first clock edge after rst deasserts.

Structure
REQ-031 The state encoding (IDLE=2'd0, FILL=2'd1, HOLD=2'd2), MEM_LO=2, MEM_HI=5 and the byte range [15:8] SHALL live in the shared package index_test_pkg, together with the downstream block's constants.
REQ-032 The block SHALL be a single module with no sub-module; the saturating counter is inline.
REQ-033 The block SHALL use no combinational loop from frame_ack to in_ready.

Verification
REQ-034 Offer bytes 11,22,33,44 with in_last on 44 -> frame_valid=1 one cycle later, mem_out[2..5]=11,22,33,44, short_frame=0.
REQ-035 Offer bytes A1,B2 with in_last on B2 -> mem_out=A1,B2,00,00, short_frame=1.
REQ-036 Offer 4 bytes with no in_last -> overrun_cnt=1, frame_valid=0, mem_out unchanged; repeat 300 times -> overrun_cnt=FF.
REQ-037 Hold a frame, keep in_valid=1 for 5 cycles, then pulse frame_ack -> in_ready=0 throughout HOLD, mem_out stable, in_ready=1 in the cycle after the ack.
REQ-038 Assert rst asynchronously after 2 bytes of FILL -> all outputs zero immediately; the next 4-byte frame lands in slots 2..5.
REQ-039 Chain the loader with the downstream no-clock index model -> out_mem_8bit[4..7] equals mem_out[5..2].
